// File: rtl/spi_pkg.sv
// Shared types and frame constants for the single-clock SPI master.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned RX_BITS    = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StShift,
    StWaitRd,
    StCapt,
    StGap
  } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, serial-in shift register; shifts toward the MSB.
module spi_shift_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             serial_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= {data_q[Width-2:0], serial_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/spi_master.sv
// SPI initiator: serializes {cmd, wdata} frames and captures RD_DATA replies.
// Optional RD_ADDR/RD_DATA sequencing check enabled by SPI_MASTER_SEQ_CHECK_EN.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [1:0] cmd_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rx_data_o,
  output logic       err_o,
  output logic       ss_n_o,
  output logic       mosi_o,
  input  logic       miso_i
);

  localparam int unsigned CntMax0 = (GAP_CYCLES > FRAME_BITS) ? GAP_CYCLES : FRAME_BITS;
  localparam int unsigned CntMax  = (RD_LATENCY > CntMax0) ? RD_LATENCY : CntMax0;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SelLast   = CntW'(1);
  localparam logic [CntW-1:0] ShiftLast = CntW'(FRAME_BITS - 1);
  localparam logic [CntW-1:0] WaitLast  = CntW'(RD_LATENCY - 1);
  localparam logic [CntW-1:0] CaptLast  = CntW'(RX_BITS - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  cmd_e                  cmd_q, cmd_d;
  logic [RX_BITS-1:0]    rx_data_q, rx_data_d;
  logic                  accept, tx_shift, rx_shift;
  logic [FRAME_BITS-1:0] tx_word;
  logic [RX_BITS-1:0]    rx_word;

  spi_shift_reg #(
    .Width(FRAME_BITS)
  ) u_tx_shreg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_data_i({cmd_i, wdata_i}),
    .shift_i    (tx_shift),
    .serial_i   (1'b0),
    .data_o     (tx_word)
  );

  spi_shift_reg #(
    .Width(RX_BITS)
  ) u_rx_shreg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (1'b0),
    .load_data_i('0),
    .shift_i    (rx_shift),
    .serial_i   (miso_i),
    .data_o     (rx_word)
  );

  // Only the TX MSB drives the line; the RX MSB is shifted out before the final copy.
  logic unused_bits;
  assign unused_bits = ^{tx_word[FRAME_BITS-2:0], rx_word[RX_BITS-1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cmd_q     <= WR_ADDR;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      rx_data_q <= rx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    rx_data_d = rx_data_q;
    accept    = 1'b0;
    tx_shift  = 1'b0;
    rx_shift  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          accept  = 1'b1;
          cmd_d   = cmd_e'(cmd_i);
          cnt_d   = '0;
          state_d = StSel;
        end
      end
      StSel: begin
        if (cnt_q == SelLast) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        tx_shift = 1'b1;
        if (cnt_q == ShiftLast) begin
          cnt_d   = '0;
          state_d = (cmd_q == RD_DATA) ? StWaitRd : StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitRd: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = '0;
          state_d = StCapt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapt: begin
        rx_shift = 1'b1;
        if (cnt_q == CaptLast) begin
          // Last sample goes straight to the output alongside the shift.
          rx_data_d = {rx_word[RX_BITS-2:0], miso_i};
          cnt_d     = '0;
          state_d   = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ss_n_o = 1'b1;
    mosi_o = 1'b0;
    done_o = 1'b0;
    busy_o = (state_q != StIdle);
    unique case (state_q)
      StSel, StShift: begin
        ss_n_o = 1'b0;
        mosi_o = tx_word[FRAME_BITS-1];
      end
      StWaitRd, StCapt: ss_n_o = 1'b0;
      StGap:            done_o = (cnt_q == '0);
      default:          ;
    endcase
  end

  assign rx_data_o = rx_data_q;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic flag_q, flag_d;
  logic err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  // flag remembers an address phase that a data read may consume.
  always_comb begin
    flag_d = flag_q;
    err_d  = err_q;
    if (accept) begin
      err_d = (cmd_e'(cmd_i) == RD_DATA) && !flag_q;
    end
    if (done_o) begin
      if (cmd_q == RD_ADDR) begin
        flag_d = 1'b1;
      end else if (cmd_q == RD_DATA) begin
        flag_d = 1'b0;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/spi_master.md
# spi_master

Initiator end of the team's single-clock SPI memory link: it drives `SS_n`/`MOSI` and captures `MISO` for the SPI slave + RAM wrapper. The serial bit rate equals `clk`, and there is no separate SCLK. A parallel host issues one 10-bit command frame per `start`. The block serializes it with the slave's select-bit preamble and, for read-data frames, deserializes the 8-bit reply.

## Interface
- `RD_LATENCY`, 1: cycles between the last command bit and the first valid `MISO` bit (1..4).
- `GAP_CYCLES`, 1: minimum `SS_n`-high cycles between frames (≥1).
- `clk` in 1: system and serial clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a frame. Accepted only when `busy`=0.
- `cmd` in 2: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA. Latched on accept.
- `wdata` in 8: address/data byte. Latched on accept.
- `busy` out 1: frame or gap in progress.
- `done` out 1: single-cycle pulse at frame end.
- `rx_data` out 8: byte captured by the last RD_DATA frame. Holds its value otherwise.
- `err` out 1: sequencing error, sticky until the next accept. Only active with the macro.
- `SS_n` out 1: slave select, active low.
- `MOSI` out 1: serial data to the slave.
- `MISO` in 1: serial data from the slave.

## Operation
- States: IDLE, SEL, SHIFT, WAIT_RD, CAPT, GAP.
- **IDLE**
  - `SS_n`=1, `MOSI`=0.
  - `start`=1 latches `cmd`/`wdata` into a 10-bit shift register {cmd, wdata} and moves to SEL.
- **SEL** (frame cycles 1–2)
  - `SS_n`=0, `MOSI`=cmd[1] for 2 cycles.
  - Cycle 1 lets the slave leave idle. Cycle 2 is the slave's read/write select bit.
- **SHIFT** (cycles 3–12)
  - `MOSI` = shift register MSB: cmd[1], cmd[0], wdata[7]…wdata[0].
  - 4-bit counter, 10 bits total.
  - After bit 10: RD_DATA goes to WAIT_RD, all other commands go to GAP.
- **WAIT_RD**: holds `SS_n`=0, `MOSI`=0 for `RD_LATENCY` cycles.
- **CAPT**
  - Samples `MISO` for 8 cycles, MSB first, into an internal shift register.
  - On the 8th sample, copies it to `rx_data` and goes to GAP.
- **GAP**
  - `SS_n`=1, `MOSI`=0, `done`=1 in the first GAP cycle only.
  - Stays `GAP_CYCLES` cycles, then returns to IDLE.
  - `busy` stays high through GAP.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` in the last GAP cycle is also ignored. The host must see `busy`=0.

## Timing
- Reset values: `SS_n`=1, `MOSI`=0, `busy`=0, `done`=0, `rx_data`=8'h00, `err`=0, state IDLE, counters 0.
- Accept at edge N: `busy`=1 and `SS_n`=0 from edge N.
- Frame length with `SS_n` low:
  - Write and RD_ADDR: 12 cycles.
  - RD_DATA: 12+`RD_LATENCY`+8 cycles (21 at default).
- `MISO` sample points: the rising edges at frame cycles 12+`RD_LATENCY`+1 through 12+`RD_LATENCY`+8.
- Back-to-back frames: the minimum `SS_n`-high time is `GAP_CYCLES`+1 cycles (IDLE accept cycle included).
- `rx_data` updates in the same edge that raises `done`.
- Reset asserted mid-frame:
  - All outputs take reset values immediately (asynchronously).
  - `SS_n` rises without completing the frame, and no `done` is issued.

## Configuration
- `SPI_MASTER_SEQ_CHECK_EN` defined:
  - A 1-bit flag sets on RD_ADDR `done` and clears on RD_DATA `done`.
  - RD_DATA accepted while the flag is clear sets `err`=1. The frame is still sent.
  - `err` clears on the next accept.
- Macro undefined: no flag, and `err` is tied to 0.

## Structure
- `spi_pkg` holds:
  - the `cmd_e` enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA),
  - the `state_e` enum,
  - `FRAME_BITS`=10 and `RX_BITS`=8.
- One sub-module, `spi_shift_reg` (parameterized width, load/shift-in/shift-out).
  - Instantiated twice: TX 10-bit and RX 8-bit.

## Test plan
- **WR_ADDR 8'h07**
  - Required: 12 cycles of `SS_n`=0.
  - Required `MOSI` sequence: 0,0,0,0,0,0,0,0,0,1,1,1.
  - Then `done` pulses once, and `SS_n`=1.
- **WR_DATA 8'h55**
  - Required `MOSI` sequence: 0,0,0,1,0,1,0,1,0,1,0,1.
  - Loopback to the slave/RAM writes 8'h55 at address 7.
- **RD_ADDR 8'h07 then RD_DATA**
  - Required: 21-cycle read frame, `rx_data`=8'h55.
  - `err`=0 with the macro defined.
- **RD_DATA with no prior RD_ADDR, macro defined**
  - Required: `err`=1 after accept.
  - The frame completes normally.
- **Back-to-back starts**
  - `start` held high continuously.
  - Required: `SS_n` high exactly 2 cycles between frames.
  - Required: starts asserted while `busy`=1 are dropped.
- **`rst_n` pulsed at frame cycle 6 of RD_DATA**
  - Required: `SS_n`=1 and `busy`=0 immediately.
  - Required: no `done`, `rx_data`=8'h00.
  - The next frame runs cleanly.
